dmem_wait: RTL
==============

# dmem_wait

Parametrised data memory for the MIPS core test system, the successor to the single-cycle data memory. It adds configurable width and depth, per-byte write enables and a programmable number of wait states behind a request/done handshake. Benches use it to exercise core stall logic against a slow memory. It sits between the core's data port and the system bench, on the same clock.

## Interface

Parameters:
- ADDR_W, 6: word-address width; depth = 2^ADDR_W words.
- DATA_W, 32: data width; must be a multiple of 8.
- LATENCY, 1: cycles from acceptance to completion; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  request strobe; sampled only while busy = 0.
- we  in  1  1 = write, 0 = read; captured with req.
- addr  in  ADDR_W  word address; captured with req.
- be  in  DATA_W/8  byte enables for writes; bit i covers din[8i+7:8i]; ignored on reads.
- din  in  DATA_W  write data; captured with req.
- dout  out  DATA_W  read data; updated only on read completion; holds otherwise.
- busy  out  1  high while a request is outstanding.
- done  out  1  one-cycle completion pulse for reads and writes.

## Operation

- Two states:
  - IDLE: busy = 0.
  - WAIT: busy = 1; a down-counter of width ceil(log2(LATENCY+1)) runs.
- IDLE, req = 1 at a clock edge: capture we, addr, be and din into holding registers, load the counter with LATENCY-1, and go to WAIT.
- IDLE, req = 0: stay in IDLE.
- WAIT, counter ≠ 0: decrement.
- WAIT, counter = 0, at that edge:
  - write: commit byte lanes with be[i] = 1; lanes with be[i] = 0 keep their old value.
  - read: load dout from the stored word.
  - return to IDLE and assert done for exactly one cycle.
- req while busy = 1 is ignored and not queued. The requester must hold or re-issue it.
- Only one request is ever outstanding. A read issued after a write sees the written data, because the write has committed before the read can be accepted.
- be = 0 on a write: nothing changes, done still pulses.
- Address range is the full 2^ADDR_W; no out-of-range case exists.
- Captured fields are used, so changing addr, din, we or be during WAIT has no effect.
- Reset (asynchronous, any time):
  - state = IDLE, counter = 0, busy = 0, done = 0, dout = 0.
  - Any outstanding write is discarded; the array is not written.
  - Array contents are not cleared by reset. Their power-up value is X; benches preload them.

## Timing

- Request accepted at edge t0 → busy high after t0.
- Completion edge is t0+LATENCY. After it: done = 1, busy = 0, and dout is valid for a read.
- done falls after edge t0+LATENCY+1.
- A new request may be accepted at edge t0+LATENCY+1, in the same cycle done is high. Maximum throughput is one access per LATENCY+1 cycles.
- LATENCY = 1 gives busy high for one cycle and done one cycle after acceptance.
- dout is registered, so there is no combinational path from addr to dout.
- Reset release is synchronous-safe: the first request can be accepted at the first edge with rst low.

## Test plan

- Reset: assert rst mid-WAIT of a write of 0xDEADBEEF to addr 5, then release → busy = 0, done = 0, dout = 0. A later read of addr 5 returns the preloaded value, not 0xDEADBEEF.
- Latency sweep with LATENCY = 1, 3 and 15: write 0x12345678 to addr 0, then read addr 0 → done arrives exactly LATENCY edges after each acceptance, dout = 0x12345678, and busy is high for LATENCY cycles.
- Byte enables: preload 0xAABBCCDD at addr 7, write 0x11223344 with be = 4'b0101 → read returns 0xAA22CC44. A write with be = 0 leaves it unchanged and done still pulses.
- Ignored request: with LATENCY = 4, pulse req to write addr 3 while busy → the addr 3 value is unchanged and only one done pulse appears.
- Back-to-back: issue a read of addr 2 at the done cycle of a write to addr 2 (data 0xCAFEF00D) → the read is accepted immediately and returns 0xCAFEF00D.
- Parametrisation: ADDR_W = 4, DATA_W = 64, write 0x0123456789ABCDEF to addr 15, read back → values match, and addr wraps at 15 with no effect on addr 0.

Source files
------------

// File: rtl/dmem_wait.sv
// Word-addressed data memory with per-byte write enables and a fixed number of
// wait states behind a req/busy/done handshake; one access outstanding at a time.
module dmem_wait #(
   parameter int ADDR_W  = 6,
   parameter int DATA_W  = 32,
   parameter int LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [DATA_W/8-1:0]   be,
   input  logic [DATA_W-1:0]     din,
   output logic [DATA_W-1:0]     dout,
   output logic                  busy,
   output logic                  done
);
   // state | meaning
   // IDLE  | no access outstanding; req is sampled
   // WAIT  | access captured; counter runs down, completes when it reaches 0

   localparam int NB    = DATA_W / 8;
   localparam int CNT_W = $clog2(LATENCY + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               hold_we;
   logic [ADDR_W-1:0]  hold_addr;
   logic [NB-1:0]      hold_be;
   logic [DATA_W-1:0]  hold_din;
   logic [DATA_W-1:0]  mem [2**ADDR_W];
   logic               commit;

   assign commit = (state == WAIT) && (cnt == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         dout      <= '0;
         hold_we   <= 1'b0;
         hold_addr <= '0;
         hold_be   <= '0;
         hold_din  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  hold_we   <= we;
                  hold_addr <= addr;
                  hold_be   <= be;
                  hold_din  <= din;
                  cnt       <= CNT_LOAD;
                  busy      <= 1'b1;
                  state     <= WAIT;
               end
            end
            WAIT: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  if (!hold_we)
                     dout <= mem[hold_addr];
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // No reset on the array: a write discarded by reset never reaches commit
   // because state is forced back to IDLE asynchronously.
   always_ff @(posedge clk) begin
      if (commit && hold_we) begin
         for (int i = 0; i < NB; i++) begin
            if (hold_be[i])
               mem[hold_addr][8*i +: 8] <= hold_din[8*i +: 8];
         end
      end
   end

endmodule
